// File: rtl/ddr3_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_pkg
// Shared constants and types for the DDR3 write packer slice.
//   LANES           : input samples packed into one DDR3 write beat
//   DEPTH_DEF       : default beat FIFO depth
//   BURST_BEATS_DEF : default beats per DDR3 write burst
//   IN_WD_DEF       : default input sample width
//   frame_state_e   : frame FSM state (WAIT_SOF until the first SOF, then RUN)
// ---------------------------------------------------------------------------
package ddr3_pkg;

  localparam int LANES           = 8;
  localparam int DEPTH_DEF       = 64;
  localparam int BURST_BEATS_DEF = 16;
  localparam int IN_WD_DEF       = 16;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } frame_state_e;

endpackage

// File: rtl/ddr3_beat_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_beat_fifo
// Synchronous show-ahead beat FIFO with occupancy count.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (clears pointers)
//   flush_i : synchronous flush; wins over push and pop in the same cycle
//   push_i  : write din_i (ignored when full)
//   din_i   : beat to write
//   pop_i   : drop the head beat (ignored when empty)
//   dout_o  : head beat, combinational (show-ahead)
//   count_o : beats stored, 0..DEPTH
// Pointers carry one extra MSB so that full (count == DEPTH) and empty
// (count == 0) are distinct while the low bits wrap modulo DEPTH.
// ---------------------------------------------------------------------------
module ddr3_beat_fifo #(
  parameter int WD    = 128,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WD-1:0]            din_i,
  input  logic                     pop_i,
  output logic [WD-1:0]            dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WD-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full    = (count_o == (AW+1)'(DEPTH));
  assign empty   = (count_o == '0);
  assign do_push = push_i && !full && !flush_i;
  assign do_pop  = pop_i && !empty && !flush_i;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_wr_packer.sv
// ---------------------------------------------------------------------------
// ddr3_wr_packer
// Packs LANES input samples into one DDR3 write beat, buffers beats in a
// show-ahead FIFO and offers bursts to the DDR3 write controller.
//   clk_ref      : single clock for this block and the controller
//   rst_n        : asynchronous active-low reset
//   in_valid     : input sample valid
//   in_data      : input sample
//   in_sof       : start of frame, qualified by in_valid
//   in_ready     : sample accepted this cycle (always high for an SOF sample)
//   ddr3_wr_req  : at least BURST_BEATS beats stored and no restart pending
//   ddr3_wr_ack  : per-beat pop strobe from the controller
//   ddr3_wr_load : one-cycle frame restart pulse, the cycle after an SOF
//   ddr3_din     : head beat, show-ahead; 0 in reset and when empty
//   fill_level   : beats stored
//   overflow     : sticky, a non-SOF sample arrived while in_ready was low
//   underflow    : sticky, ddr3_wr_ack arrived with the FIFO empty
//   dbg_state    : frame FSM state, for observation only
// Handshake: a sample transfers on any cycle with in_valid && in_ready;
// in_ready does not depend on in_data and is forced high for SOF samples.
// Build option: define DDR3_WR_PACKER_LANE_SWAP_EN to present lane 0 in the
// top IN_WD bits of ddr3_din instead of the bottom; timing is unchanged.
// ---------------------------------------------------------------------------
module ddr3_wr_packer
  import ddr3_pkg::*;
#(
  parameter int IN_WD       = IN_WD_DEF,
  parameter int BEAT_WD     = LANES * IN_WD_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int BURST_BEATS = BURST_BEATS_DEF
) (
  input  logic                   clk_ref,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [IN_WD-1:0]       in_data,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic                   ddr3_wr_req,
  input  logic                   ddr3_wr_ack,
  output logic                   ddr3_wr_load,
  output logic [BEAT_WD-1:0]     ddr3_din,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic                   underflow,
  output frame_state_e           dbg_state
);

  localparam int FILL_WD = $clog2(DEPTH) + 1;
  localparam int LANE_WD = $clog2(LANES);

  frame_state_e         state_q;
  logic [LANE_WD-1:0]   lane_cnt_q;
  logic [BEAT_WD-1:0]   partial_q;
  logic                 load_q;
  logic                 overflow_q;
  logic                 underflow_q;

  logic                 sof_acc;
  logic                 data_acc;
  logic                 last_lane;
  logic                 push;
  logic                 pop;
  logic [BEAT_WD-1:0]   beat_asm;
  logic [BEAT_WD-1:0]   head;
  logic [BEAT_WD-1:0]   head_ordered;

  // An SOF is always taken, whatever the fill level.
  assign sof_acc   = in_valid && in_sof;
  // The completing push is written into the FIFO in the same cycle it is
  // accepted, so fill_level already includes it by the next decision and
  // no separate pending-push term is needed here.
  assign in_ready  = rst_n && (sof_acc || (fill_level < FILL_WD'(DEPTH)));
  assign data_acc  = in_valid && in_ready && !in_sof && (state_q == RUN);
  assign last_lane = (lane_cnt_q == LANE_WD'(LANES - 1));
  assign push      = data_acc && last_lane;
  // A flush discards any pop requested in the same cycle.
  assign pop       = ddr3_wr_ack && (fill_level != '0) && !sof_acc;

  always_comb begin
    beat_asm = partial_q;
    beat_asm[int'(lane_cnt_q)*IN_WD +: IN_WD] = in_data;
  end

  ddr3_beat_fifo #(
    .WD    (BEAT_WD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_ref),
    .rst_ni  (rst_n),
    .flush_i (sof_acc),
    .push_i  (push),
    .din_i   (beat_asm),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fill_level)
  );

`ifdef DDR3_WR_PACKER_LANE_SWAP_EN
  always_comb begin
    head_ordered = '0;
    for (int k = 0; k < LANES; k++) begin
      head_ordered[k*IN_WD +: IN_WD] = head[(LANES-1-k)*IN_WD +: IN_WD];
    end
  end
`else
  assign head_ordered = head;
`endif

  // Gate stale storage so the bus reads 0 in reset and whenever empty.
  assign ddr3_din     = (rst_n && (fill_level != '0)) ? head_ordered : '0;
  assign ddr3_wr_req  = (fill_level >= FILL_WD'(BURST_BEATS)) && !load_q;
  assign ddr3_wr_load = load_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_SOF;
      lane_cnt_q  <= '0;
      partial_q   <= '0;
      load_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      load_q <= sof_acc;
      if (sof_acc) begin
        // The SOF sample opens the new frame as lane 0.
        state_q     <= RUN;
        partial_q   <= {{(BEAT_WD-IN_WD){1'b0}}, in_data};
        lane_cnt_q  <= LANE_WD'(1);
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (data_acc) begin
          partial_q  <= last_lane ? '0 : beat_asm;
          lane_cnt_q <= last_lane ? '0 : lane_cnt_q + 1'b1;
        end
        if (in_valid && !in_ready) begin
          overflow_q <= 1'b1;
        end
        if (ddr3_wr_ack && (fill_level == '0)) begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr3_wr_packer.sv
// ---------------------------------------------------------------------------
// tb_ddr3_wr_packer
// Randomised and directed stimulus against a queue-based reference model of
// the packer: a beat queue, a lane array and the two sticky flags.
// ---------------------------------------------------------------------------
module tb_ddr3_wr_packer;
  import ddr3_pkg::*;

  localparam int IN_WD   = 16;
  localparam int BEAT_WD = 128;
  localparam int DEPTH   = 64;
  localparam int BURST   = 16;
  localparam int FW      = 7;

`ifdef DDR3_WR_PACKER_LANE_SWAP_EN
  localparam logic [BEAT_WD-1:0] BEAT0_EXP = 128'h0000_0001_0002_0003_0004_0005_0006_0007;
  localparam int LANE0_LSB = BEAT_WD - IN_WD;
`else
  localparam logic [BEAT_WD-1:0] BEAT0_EXP = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam int LANE0_LSB = 0;
`endif

  // clock / reset / DUT
  logic               clk_ref;
  logic               rst_n;
  logic               in_valid;
  logic [IN_WD-1:0]   in_data;
  logic               in_sof;
  logic               in_ready;
  logic               ddr3_wr_req;
  logic               ddr3_wr_ack;
  logic               ddr3_wr_load;
  logic [BEAT_WD-1:0] ddr3_din;
  logic [FW-1:0]      fill_level;
  logic               overflow;
  logic               underflow;
  frame_state_e       dbg_state;

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  ddr3_wr_packer #(
    .IN_WD(IN_WD), .BEAT_WD(BEAT_WD), .DEPTH(DEPTH), .BURST_BEATS(BURST)
  ) dut (
    .clk_ref      (clk_ref),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_sof       (in_sof),
    .in_ready     (in_ready),
    .ddr3_wr_req  (ddr3_wr_req),
    .ddr3_wr_ack  (ddr3_wr_ack),
    .ddr3_wr_load (ddr3_wr_load),
    .ddr3_din     (ddr3_din),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .underflow    (underflow),
    .dbg_state    (dbg_state)
  );

  // reference model / scoreboard
  logic [BEAT_WD-1:0] exp_q[$];
  logic [IN_WD-1:0]   m_lane[LANES];
  int                 m_lcnt;
  bit                 m_run, m_ovf, m_unf, m_load;
  int                 n_vec, n_err;

  function automatic logic [BEAT_WD-1:0] pack_beat();
    logic [BEAT_WD-1:0] b;
    b = '0;
    for (int k = 0; k < LANES; k++) begin
`ifdef DDR3_WR_PACKER_LANE_SWAP_EN
      b[(LANES-1-k)*IN_WD +: IN_WD] = m_lane[k];
`else
      b[k*IN_WD +: IN_WD] = m_lane[k];
`endif
    end
    return b;
  endfunction

  function automatic bit exp_ready();
    return (in_valid && in_sof) || (exp_q.size() < DEPTH);
  endfunction

  function automatic logic [BEAT_WD-1:0] exp_din();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  function automatic bit exp_req();
    return (exp_q.size() >= BURST) && !m_load;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int k = 0; k < LANES; k++) m_lane[k] = '0;
    m_lcnt = 0; m_run = 0; m_ovf = 0; m_unf = 0; m_load = 0;
  endfunction

  // One clock of the model, using the inputs currently applied.
  function automatic void model_apply();
    bit rdy;
    rdy = exp_ready();
    if (in_valid && in_sof) begin
      exp_q.delete();
      for (int k = 0; k < LANES; k++) m_lane[k] = '0;
      m_lane[0] = in_data;
      m_lcnt = 1; m_run = 1; m_ovf = 0; m_unf = 0; m_load = 1;
    end else begin
      m_load = 0;
      if (ddr3_wr_ack) begin
        if (exp_q.size() == 0) m_unf = 1;
        else void'(exp_q.pop_front());
      end
      if (in_valid && !rdy) m_ovf = 1;
      if (in_valid && rdy && m_run) begin
        m_lane[m_lcnt] = in_data;
        m_lcnt++;
        if (m_lcnt == LANES) begin
          exp_q.push_back(pack_beat());
          m_lcnt = 0;
        end
      end
    end
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic s, input logic [IN_WD-1:0] d, input logic a);
    in_valid = v; in_sof = s; in_data = d; ddr3_wr_ack = a;
    #1;
  endtask

  task automatic step();
    if (rst_n) model_apply();
    @(posedge clk_ref);
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 1'b1, 16'h1234, 1'b1);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_vec++; if (ddr3_din !== '0) begin n_err++; $display("FAIL rst_din: got %h want 0", ddr3_din); end
    step(); step();
    n_vec++; if (fill_level !== '0) begin n_err++; $display("FAIL rst_fill: got %0d want 0", fill_level); end
    n_vec++; if ({overflow, underflow, ddr3_wr_load, ddr3_wr_req} !== 4'b0) begin
      n_err++; $display("FAIL rst_flags: got %b want 0000", {overflow, underflow, ddr3_wr_load, ddr3_wr_req}); end
    n_vec++; if ((dbg_state == RUN) !== 1'b0) begin n_err++; $display("FAIL rst_state: got RUN want WAIT_SOF"); end
    drive(1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    drive(1'b1, 1'b1, 16'h0000, 1'b0);
    step();
    for (int i = 1; i < 128; i++) begin
      drive(1'b1, 1'b0, IN_WD'(i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (fill_level !== FW'(16)) begin n_err++; $display("FAIL t1_fill: got %0d want 16", fill_level); end
    n_vec++; if (ddr3_wr_req !== 1'b1) begin n_err++; $display("FAIL t1_req: got %b want 1", ddr3_wr_req); end
    n_vec++; if (ddr3_din !== BEAT0_EXP) begin n_err++; $display("FAIL t1_beat0: got %h want %h", ddr3_din, BEAT0_EXP); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      n_vec++; if (ddr3_din !== exp_din()) begin n_err++; $display("FAIL t2_beat%0d: got %h want %h", i, ddr3_din, exp_din()); end
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (fill_level !== '0) begin n_err++; $display("FAIL t2_fill: got %0d want 0", fill_level); end
    n_vec++; if (ddr3_wr_req !== 1'b0) begin n_err++; $display("FAIL t2_req: got %b want 0", ddr3_wr_req); end
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL t2_unf: got %b want 0", underflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH * LANES; i++) begin
      drive(1'b1, 1'b0, IN_WD'($urandom), 1'b0);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t3_ready_hi%0d: got %b want 1", i, in_ready); end
      step();
    end
    drive(1'b1, 1'b0, IN_WD'($urandom), 1'b0);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t3_ready_lo: got %b want 0", in_ready); end
    n_vec++; if (fill_level !== FW'(DEPTH)) begin n_err++; $display("FAIL t3_fill: got %0d want %0d", fill_level, DEPTH); end
    step();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (overflow !== 1'b1 || m_ovf !== 1'b1) begin n_err++; $display("FAIL t3_ovf: got %b want 1", overflow); end
    n_vec++; if (fill_level !== FW'(exp_q.size())) begin n_err++; $display("FAIL t3_fill_after: got %0d want %0d", fill_level, exp_q.size()); end
    n_vec++; if (ddr3_din !== exp_din()) begin n_err++; $display("FAIL t3_head: got %h want %h", ddr3_din, exp_din()); end
  endtask

  task automatic test_underflow();
    drive(1'b1, 1'b1, IN_WD'($urandom), 1'b0);
    step();
    drive(1'b0, 1'b0, '0, 1'b1);
    step();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL t4_unf: got %b want 1", underflow); end
    n_vec++; if (fill_level !== '0) begin n_err++; $display("FAIL t4_fill: got %0d want 0", fill_level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL t4_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_sof_flush();
    logic [IN_WD-1:0]   sof_d;
    logic [BEAT_WD-1:0] dv;
    drive(1'b1, 1'b1, IN_WD'($urandom), 1'b0);
    step();
    drive(1'b0, 1'b0, '0, 1'b1);
    step();
    for (int i = 0; i < 20 * LANES + 2; i++) begin
      drive(1'b1, 1'b0, IN_WD'($urandom), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (fill_level !== FW'(20)) begin n_err++; $display("FAIL t5_pre_fill: got %0d want 20", fill_level); end
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL t5_pre_unf: got %b want 1", underflow); end
    sof_d = IN_WD'($urandom);
    drive(1'b1, 1'b1, sof_d, 1'b1);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t5_sof_ready: got %b want 1", in_ready); end
    step();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (fill_level !== '0) begin n_err++; $display("FAIL t5_fill: got %0d want 0", fill_level); end
    n_vec++; if (ddr3_wr_load !== 1'b1) begin n_err++; $display("FAIL t5_load_on: got %b want 1", ddr3_wr_load); end
    n_vec++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL t5_flags: got %b want 00", {overflow, underflow}); end
    step();
    n_vec++; if (ddr3_wr_load !== 1'b0) begin n_err++; $display("FAIL t5_load_off: got %b want 0", ddr3_wr_load); end
    for (int i = 0; i < LANES - 1; i++) begin
      drive(1'b1, 1'b0, IN_WD'($urandom), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    dv = ddr3_din;
    n_vec++; if (dv[LANE0_LSB +: IN_WD] !== sof_d) begin n_err++; $display("FAIL t5_lane0: got %h want %h", dv[LANE0_LSB +: IN_WD], sof_d); end
    n_vec++; if (ddr3_din !== exp_din()) begin n_err++; $display("FAIL t5_beat: got %h want %h", ddr3_din, exp_din()); end
  endtask

  task automatic test_back_to_back();
    logic v, s, a;
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 99) < ((exp_q.size() > 40) ? 60 : 20));
      drive(v, s, IN_WD'($urandom), a);
      n_vec++; if (in_ready !== exp_ready()) begin n_err++; $display("FAIL bb_ready@%0d: got %b want %b", i, in_ready, exp_ready()); end
      n_vec++; if (ddr3_din !== exp_din()) begin n_err++; $display("FAIL bb_din@%0d: got %h want %h", i, ddr3_din, exp_din()); end
      n_vec++; if (ddr3_wr_req !== exp_req()) begin n_err++; $display("FAIL bb_req@%0d: got %b want %b", i, ddr3_wr_req, exp_req()); end
      n_vec++; if (fill_level !== FW'(exp_q.size())) begin n_err++; $display("FAIL bb_fill@%0d: got %0d want %0d", i, fill_level, exp_q.size()); end
      n_vec++; if ({ddr3_wr_load, overflow, underflow} !== {m_load, m_ovf, m_unf}) begin
        n_err++; $display("FAIL bb_flags@%0d: got %b want %b", i, {ddr3_wr_load, overflow, underflow}, {m_load, m_ovf, m_unf}); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, IN_WD'($urandom), 1'b0);
    step();
    for (int i = 0; i < 40 * LANES; i++) begin
      drive(1'b1, 1'b0, IN_WD'($urandom), (i > 200));
      step();
    end
    drive(1'b1, 1'b0, IN_WD'($urandom), 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if ({in_ready, ddr3_wr_req, ddr3_wr_load, overflow, underflow} !== 5'b0) begin
      n_err++; $display("FAIL t6_outs: got %b want 00000", {in_ready, ddr3_wr_req, ddr3_wr_load, overflow, underflow}); end
    n_vec++; if (fill_level !== '0) begin n_err++; $display("FAIL t6_fill: got %0d want 0", fill_level); end
    n_vec++; if (ddr3_din !== '0) begin n_err++; $display("FAIL t6_din: got %h want 0", ddr3_din); end
    step(); step();
    drive(1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 2 * LANES; i++) begin
      drive(1'b1, 1'b0, IN_WD'($urandom), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (fill_level !== '0) begin n_err++; $display("FAIL t6_discard: got %0d want 0", fill_level); end
    for (int i = 0; i < LANES; i++) begin
      drive(1'b1, (i == 0), IN_WD'(i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (fill_level !== FW'(1)) begin n_err++; $display("FAIL t6_fill1: got %0d want 1", fill_level); end
    n_vec++; if (ddr3_din !== BEAT0_EXP) begin n_err++; $display("FAIL t6_beat0: got %h want %h", ddr3_din, BEAT0_EXP); end
  endtask

  // sequence and final report
  initial begin
    n_vec = 0;
    n_err = 0;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0; ddr3_wr_ack = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_underflow();
    test_sof_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
